// File: rtl/quadratic_coeff_loader.sv
// Coefficient entry front-end for the quadratic solver. Two debounced pushbuttons
// step a four-state FSM that captures a, b, c from switches and then enables the solver.

module quadratic_coeff_loader_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync_1;
  logic        sync_2;
  logic        level;
  logic        level_q;
  logic [15:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      count   <= '0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      level_q <= level;
      if (sync_2 == level) begin
        count <= '0;
      end else if (count == LAST_COUNT) begin
        level <= ~level;
        count <= '0;
      end else begin
        count <= count + 16'd1;
      end
    end
  end

  // Pulse is combinational off the debounced level so the FSM acts one edge later.
  assign rise = level & ~level_q;

endmodule

module quadratic_coeff_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_sw,
  input  logic       i_btn_load,
  input  logic       i_btn_clear,
  output logic [4:0] o_a,
  output logic [4:0] o_b,
  output logic [4:0] o_c,
  output logic       o_enable,
  output logic [1:0] o_state,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_C     = 2'b10,
    S_SOLVE = 2'b11
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       load_pulse;
  logic       clear_pulse;
  logic [4:0] sw_norm;

  quadratic_coeff_loader_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_db (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .raw   (i_btn_load),
    .rise  (load_pulse)
  );

  quadratic_coeff_loader_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .raw   (i_btn_clear),
    .rise  (clear_pulse)
  );

  // Negative zero collapses to +0 so the solver sees a single encoding of zero.
  assign sw_norm = (i_sw == 5'b10000) ? 5'b00000 : i_sw;

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (clear_pulse) begin
      next_state = S_A;
    end else if (load_pulse) begin
      unique case (state)
        S_A:     next_state = S_B;
        S_B:     next_state = S_C;
        S_C:     next_state = S_SOLVE;
        S_SOLVE: next_state = S_A;
        default: next_state = S_A;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_A;
      o_a      <= '0;
      o_b      <= '0;
      o_c      <= '0;
      o_enable <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      state    <= next_state;
      o_enable <= (next_state != S_SOLVE);
      o_done   <= (state == S_C) && (next_state == S_SOLVE);
      if (clear_pulse) begin
        o_a <= '0;
        o_b <= '0;
        o_c <= '0;
      end else if (load_pulse) begin
        unique case (state)
          S_A:     o_a <= sw_norm;
          S_B:     o_b <= sw_norm;
          S_C:     o_c <= sw_norm;
          default: ;
        endcase
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_quadratic_coeff_loader.sv
// Directed bench for quadratic_coeff_loader with DEBOUNCE_CYCLES=4: entry sequence,
// press latency, bounce rejection, clear priority, negative zero and reset behaviour.

module tb_quadratic_coeff_loader;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [4:0] i_sw;
  logic       i_btn_load;
  logic       i_btn_clear;
  logic [4:0] o_a;
  logic [4:0] o_b;
  logic [4:0] o_c;
  logic       o_enable;
  logic [1:0] o_state;
  logic       o_done;

  int checks_total  = 0;
  int checks_passed = 0;

  quadratic_coeff_loader #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sw        (i_sw),
    .i_btn_load  (i_btn_load),
    .i_btn_clear (i_btn_clear),
    .o_a         (o_a),
    .o_b         (o_b),
    .o_c         (o_c),
    .o_enable    (o_enable),
    .o_state     (o_state),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change and outputs are sampled on the falling edge; each call
  // advances exactly n rising edges.
  task automatic cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks_total++;
    assert (observed === expected) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Raw high for 7 edges: the pulse is acted on at the 7th (k+6), so on return
  // the load has just taken effect and the button is still held.
  task automatic hold_load(input logic [4:0] sw);
    i_sw       = sw;
    i_btn_load = 1'b1;
    cycles(7);
  endtask

  task automatic release_buttons();
    i_btn_load  = 1'b0;
    i_btn_clear = 1'b0;
    cycles(8);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_sw        = 5'b00000;
    i_btn_load  = 1'b0;
    i_btn_clear = 1'b0;
    cycles(3);
    check("rst_state",  8'(o_state),  8'd0);
    check("rst_a",      8'(o_a),      8'd0);
    check("rst_b",      8'(o_b),      8'd0);
    check("rst_c",      8'(o_c),      8'd0);
    check("rst_enable", 8'(o_enable), 8'd1);
    check("rst_done",   8'(o_done),   8'd0);
    i_rst_n = 1'b1;
    cycles(2);

    // Latency: raw first sampled high at edge k, state must move at k+6.
    i_sw       = 5'b00001;
    i_btn_load = 1'b1;
    cycles(6);
    check("lat_not_early", 8'(o_state), 8'd0);
    cycles(1);
    check("lat_advance",   8'(o_state), 8'd1);
    check("entry_a",       8'(o_a),     8'b00001);
    // Held button with switches changing: no further capture or advance.
    i_sw = 5'b11111;
    cycles(4);
    check("held_one_pulse", 8'(o_state), 8'd1);
    check("held_b_untouched", 8'(o_b), 8'd0);
    release_buttons();
    check("sw_ignored_state", 8'(o_state), 8'd1);

    hold_load(5'b10011);
    check("entry_state_c", 8'(o_state), 8'd2);
    check("entry_b",       8'(o_b),     8'b10011);
    check("enable_in_c",   8'(o_enable), 8'd1);
    release_buttons();

    hold_load(5'b00010);
    check("entry_solve",   8'(o_state),  8'd3);
    check("entry_c",       8'(o_c),      8'b00010);
    check("solve_enable",  8'(o_enable), 8'd0);
    check("done_high",     8'(o_done),   8'd1);
    cycles(1);
    check("done_one_cycle", 8'(o_done),  8'd0);
    release_buttons();
    check("solve_a", 8'(o_a), 8'b00001);
    check("solve_b", 8'(o_b), 8'b10011);

    // Load in S_SOLVE returns to S_A and keeps the coefficients.
    hold_load(5'b01111);
    check("solve_to_a",   8'(o_state),  8'd0);
    check("retain_a",     8'(o_a),      8'b00001);
    check("retain_c",     8'(o_c),      8'b00010);
    check("enable_again", 8'(o_enable), 8'd1);
    release_buttons();

    hold_load(5'b10000);
    check("negzero_a",     8'(o_a),     8'b00000);
    check("negzero_state", 8'(o_state), 8'd1);
    release_buttons();

    // Reach S_B with o_a=00101, then press both buttons together.
    i_btn_clear = 1'b1;
    cycles(7);
    check("clear_state", 8'(o_state), 8'd0);
    check("clear_c",     8'(o_c),     8'd0);
    release_buttons();
    hold_load(5'b00101);
    check("pre_sim_a", 8'(o_a), 8'b00101);
    release_buttons();
    i_sw        = 5'b11111;
    i_btn_load  = 1'b1;
    i_btn_clear = 1'b1;
    cycles(7);
    check("sim_state", 8'(o_state), 8'd0);
    check("sim_a",     8'(o_a),     8'd0);
    check("sim_b",     8'(o_b),     8'd0);
    release_buttons();

    // Bounce shorter than the debounce window must not advance.
    i_btn_load = 1'b1; cycles(3);
    i_btn_load = 1'b0; cycles(1);
    i_btn_load = 1'b1; cycles(3);
    i_btn_load = 1'b0; cycles(8);
    check("bounce_no_change", 8'(o_state), 8'd0);
    i_sw = 5'b00110;
    i_btn_load = 1'b1; cycles(10);
    release_buttons();
    check("bounce_then_held", 8'(o_state), 8'd1);
    check("bounce_a",         8'(o_a),     8'b00110);

    // Mid-entry reset in S_C.
    hold_load(5'b00111);
    release_buttons();
    check("pre_reset_state", 8'(o_state), 8'd2);
    i_rst_n = 1'b0;
    cycles(1);
    i_rst_n = 1'b1;
    check("mid_rst_state",  8'(o_state),  8'd0);
    check("mid_rst_a",      8'(o_a),      8'd0);
    check("mid_rst_b",      8'(o_b),      8'd0);
    check("mid_rst_enable", 8'(o_enable), 8'd1);
    check("mid_rst_done",   8'(o_done),   8'd0);

    // Button held through reset release gives one pulse after the full period.
    cycles(2);
    i_rst_n    = 1'b0;
    i_btn_load = 1'b1;
    i_sw       = 5'b01001;
    cycles(2);
    i_rst_n = 1'b1;
    cycles(6);
    check("held_rst_not_early", 8'(o_state), 8'd0);
    cycles(1);
    check("held_rst_advance",   8'(o_state), 8'd1);
    check("held_rst_a",         8'(o_a),     8'b01001);
    release_buttons();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
